// File: rtl/naneye_tx_encoder.sv
// NanEye-style serial transmitter: 10-bit pixels in over valid/ready, Manchester-coded
// words framed by a constant-high frame sync and constant-low line syncs on TX_DATA.
module naneye_tx_encoder #(
   parameter int D_WIDTH         = 10,
   parameter int COLS            = 250,
   parameter int ROWS            = 250,
   parameter int HALF_DIV        = 1,
   parameter int FRAME_SYNC_BITS = 16,
   parameter int LINE_SYNC_BITS  = 8
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   input  logic               ENABLE,
   input  logic [D_WIDTH-1:0] PIX_DATA,
   input  logic               PIX_VALID,
   output logic               PIX_READY,
   output logic               TX_DATA,
   output logic               TX_OE_N,
   output logic               FRAME_START,
   output logic               LINE_START,
   output logic               UNDERRUN
);

   // state | meaning
   // IDLE  | output disabled, waiting for ENABLE
   // FSYNC | frame sync, TX_DATA held high (Manchester violation)
   // LSYNC | line sync, TX_DATA held low
   // PIXEL | Manchester words: start, data MSB first, stop

   localparam int WORD_BITS = D_WIDTH + 2;
   localparam int SYNC_MAX  = (FRAME_SYNC_BITS > LINE_SYNC_BITS) ? FRAME_SYNC_BITS : LINE_SYNC_BITS;
   localparam int BIT_RANGE = (SYNC_MAX > WORD_BITS) ? SYNC_MAX : WORD_BITS;
   localparam int HALF_W    = (HALF_DIV > 1)  ? $clog2(HALF_DIV)  : 1;
   localparam int BIT_W     = (BIT_RANGE > 1) ? $clog2(BIT_RANGE) : 1;
   localparam int COL_W     = (COLS > 1)      ? $clog2(COLS)      : 1;
   localparam int ROW_W     = (ROWS > 1)      ? $clog2(ROWS)      : 1;

   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_DIV - 1);
   localparam logic [BIT_W-1:0]  FS_LAST   = BIT_W'(FRAME_SYNC_BITS - 1);
   localparam logic [BIT_W-1:0]  LS_LAST   = BIT_W'(LINE_SYNC_BITS - 1);
   localparam logic [BIT_W-1:0]  WORD_LAST = BIT_W'(WORD_BITS - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, FSYNC, LSYNC, PIXEL} state_t;

   state_t              state, state_nxt;
   logic [HALF_W-1:0]   half_cnt, half_nxt;
   logic                phase, phase_nxt;
   logic [BIT_W-1:0]    bit_cnt, bit_nxt;
   logic [COL_W-1:0]    col_cnt, col_nxt;
   logic [ROW_W-1:0]    row_cnt, row_nxt;
   logic [D_WIDTH-1:0]  word, word_nxt;
   logic                tx_data_nxt, tx_oe_n_nxt, pix_ready_nxt;
   logic                frame_start_nxt, line_start_nxt, underrun_nxt;
   logic                half_end, bit_end, slot_end_nxt, bit_val;
   logic [WORD_BITS-1:0] frame_bits;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         half_cnt    <= '0;
         phase       <= 1'b0;
         bit_cnt     <= '0;
         col_cnt     <= '0;
         row_cnt     <= '0;
         word        <= '0;
         TX_DATA     <= 1'b0;
         TX_OE_N     <= 1'b1;
         PIX_READY   <= 1'b0;
         FRAME_START <= 1'b0;
         LINE_START  <= 1'b0;
         UNDERRUN    <= 1'b0;
      end else begin
         state       <= state_nxt;
         half_cnt    <= half_nxt;
         phase       <= phase_nxt;
         bit_cnt     <= bit_nxt;
         col_cnt     <= col_nxt;
         row_cnt     <= row_nxt;
         word        <= word_nxt;
         TX_DATA     <= tx_data_nxt;
         TX_OE_N     <= tx_oe_n_nxt;
         PIX_READY   <= pix_ready_nxt;
         FRAME_START <= frame_start_nxt;
         LINE_START  <= line_start_nxt;
         UNDERRUN    <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      half_nxt        = half_cnt;
      phase_nxt       = phase;
      bit_nxt         = bit_cnt;
      col_nxt         = col_cnt;
      row_nxt         = row_cnt;
      frame_start_nxt = 1'b0;
      line_start_nxt  = 1'b0;
      // PIX_READY marks the transfer edge; a missing pixel is sent as zero, never retried
      word_nxt        = PIX_READY ? (PIX_VALID ? PIX_DATA : '0) : word;
      underrun_nxt    = PIX_READY & ~PIX_VALID;
      half_end        = (half_cnt == HALF_LAST);
      bit_end         = half_end & phase;

      if (state == IDLE) begin
         if (ENABLE) begin
            state_nxt       = FSYNC;
            half_nxt        = '0;
            phase_nxt       = 1'b0;
            bit_nxt         = '0;
            col_nxt         = '0;
            row_nxt         = '0;
            frame_start_nxt = 1'b1;
         end
      end else begin
         if (half_end) begin
            half_nxt  = '0;
            phase_nxt = ~phase;
         end else begin
            half_nxt  = half_cnt + 1'b1;
         end
         if (bit_end) begin
            bit_nxt = bit_cnt + 1'b1;
            case (state)
               FSYNC: begin
                  if (bit_cnt == FS_LAST) begin
                     state_nxt      = LSYNC;
                     bit_nxt        = '0;
                     row_nxt        = '0;
                     line_start_nxt = 1'b1;
                  end
               end
               LSYNC: begin
                  if (bit_cnt == LS_LAST) begin
                     state_nxt = PIXEL;
                     bit_nxt   = '0;
                     col_nxt   = '0;
                  end
               end
               PIXEL: begin
                  if (bit_cnt == WORD_LAST) begin
                     bit_nxt = '0;
                     if (col_cnt != COL_LAST) begin
                        col_nxt = col_cnt + 1'b1;
                     end else if (row_cnt != ROW_LAST) begin
                        row_nxt        = row_cnt + 1'b1;
                        state_nxt      = LSYNC;
                        line_start_nxt = 1'b1;
                     end else if (ENABLE) begin
                        state_nxt       = FSYNC;
                        frame_start_nxt = 1'b1;
                     end else begin
                        state_nxt = IDLE;
                        col_nxt   = '0;
                        row_nxt   = '0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      frame_bits = {1'b1, word_nxt, 1'b0};
      bit_val    = 1'b0;
      for (int i = 0; i < WORD_BITS; i++) begin
         if (bit_nxt == BIT_W'(WORD_BITS - 1 - i)) bit_val = frame_bits[i];
      end

      case (state_nxt)
         FSYNC:   tx_data_nxt = 1'b1;
         PIXEL:   tx_data_nxt = bit_val ^ phase_nxt;
         default: tx_data_nxt = 1'b0;
      endcase
      tx_oe_n_nxt = (state_nxt == IDLE);

      // ready lands on the final cycle of the period that precedes each word
      slot_end_nxt  = (half_nxt == HALF_LAST) & phase_nxt;
      pix_ready_nxt = slot_end_nxt &
                      (((state_nxt == LSYNC) && (bit_nxt == LS_LAST)) ||
                       ((state_nxt == PIXEL) && (bit_nxt == WORD_LAST) && (col_nxt != COL_LAST)));
   end

endmodule

// File: tb/tb_naneye_tx_encoder.sv
// Directed bench for naneye_tx_encoder with a small 4x2 frame geometry.
module tb_naneye_tx_encoder;

   localparam int D_WIDTH = 10;
   localparam int COLS    = 4;
   localparam int ROWS    = 2;
   localparam int HALF_DIV = 2;
   localparam int FSB     = 8;
   localparam int LSB     = 4;

   logic               CLOCK = 1'b0;
   logic               RESET_N;
   logic               ENABLE;
   logic [D_WIDTH-1:0] PIX_DATA;
   logic               PIX_VALID;
   logic               PIX_READY, TX_DATA, TX_OE_N, FRAME_START, LINE_START, UNDERRUN;

   naneye_tx_encoder #(
      .D_WIDTH(D_WIDTH), .COLS(COLS), .ROWS(ROWS), .HALF_DIV(HALF_DIV),
      .FRAME_SYNC_BITS(FSB), .LINE_SYNC_BITS(LSB)
   ) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE),
      .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .TX_DATA(TX_DATA), .TX_OE_N(TX_OE_N), .FRAME_START(FRAME_START),
      .LINE_START(LINE_START), .UNDERRUN(UNDERRUN)
   );

   always #5 CLOCK = ~CLOCK;

   int tests = 0;
   int fails = 0;
   int slot;
   logic [D_WIDTH-1:0] pix [8];
   logic               val [8];
   logic [1023:0] tx_a, oe_a, rdy_a, fs_a, ls_a, ur_a;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int cnt(input logic [1023:0] v, input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic logic [11:0] dec(input int s);
      logic [11:0] w;
      for (int b = 0; b < 12; b++) w[11-b] = tx_a[s + 4*b];
      return w;
   endfunction

   function automatic int manch_bad(input int s);
      int bad = 0;
      for (int b = 0; b < 12; b++) begin
         if (!(tx_a[s+4*b] == tx_a[s+4*b+1] && tx_a[s+4*b+2] == tx_a[s+4*b+3] &&
               tx_a[s+4*b] != tx_a[s+4*b+2])) bad++;
      end
      return bad;
   endfunction

   function automatic int wstart(input int r, input int c);
      return 48 + r*208 + c*48;
   endfunction

   // Cycle 0 is the first cycle after the edge that samples ENABLE in IDLE.
   task automatic capture(input int n, input int en_cycles, input int rst_at);
      int pend = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK); #1;
         tx_a[i] = TX_DATA; oe_a[i] = TX_OE_N; rdy_a[i] = PIX_READY;
         fs_a[i] = FRAME_START; ls_a[i] = LINE_START; ur_a[i] = UNDERRUN;
         if (pend != 0) slot = (slot + 1) % 8;
         pend = PIX_READY ? 1 : 0;
         PIX_DATA  = pix[slot];
         PIX_VALID = val[slot];
         if (i + 1 >= en_cycles) ENABLE = 1'b0;
         if (i == rst_at) begin
            #2 RESET_N = 1'b0;
            #1;
            chk_eq("rst_mid_oe_n",   TX_OE_N, 1);
            chk_eq("rst_mid_tx",     TX_DATA, 0);
            chk_eq("rst_mid_ready",  PIX_READY, 0);
            chk_eq("rst_mid_flags",  {FRAME_START, LINE_START, UNDERRUN}, 0);
            break;
         end
      end
   endtask

   task automatic start_frame();
      slot      = 0;
      PIX_DATA  = pix[0];
      PIX_VALID = val[0];
      ENABLE    = 1'b1;
   endtask

   task automatic check_words(input string tag);
      for (int k = 0; k < 8; k++) begin
         chk_eq($sformatf("%s_word%0d", tag, k), dec(wstart(k/4, k%4)),
                val[k] ? {1'b1, pix[k], 1'b0} : 12'h800);
         chk_eq($sformatf("%s_manch%0d", tag, k), manch_bad(wstart(k/4, k%4)), 0);
      end
   endtask

   initial begin
      pix[0] = 10'h2AA; pix[1] = 10'h155; pix[2] = 10'h3FF; pix[3] = 10'h000;
      pix[4] = 10'h001; pix[5] = 10'h200; pix[6] = 10'h123; pix[7] = 10'h0F0;
      for (int k = 0; k < 8; k++) val[k] = 1'b1;
      RESET_N = 1'b1; ENABLE = 1'b0; PIX_DATA = '0; PIX_VALID = 1'b0;
      #1 RESET_N = 1'b0;
      #2;
      chk_eq("reset_oe_n", TX_OE_N, 1);
      chk_eq("reset_tx", TX_DATA, 0);
      chk_eq("reset_ready", PIX_READY, 0);
      chk_eq("reset_flags", {FRAME_START, LINE_START, UNDERRUN}, 0);
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK) RESET_N = 1'b1;
      @(posedge CLOCK); #1;
      chk_eq("idle_oe_n", TX_OE_N, 1);

      // single frame, ENABLE held for a while then dropped
      start_frame();
      capture(460, 100, -1);
      chk_eq("t1_oe_low", 460 - cnt(oe_a, 0, 459), 448);
      chk_eq("t1_oe_first", oe_a[0], 0);
      chk_eq("t1_oe_last", oe_a[447], 0);
      chk_eq("t1_oe_idle", oe_a[448], 1);
      chk_eq("t1_ready_cnt", cnt(rdy_a, 0, 459), 8);
      chk_eq("t1_ready_first", rdy_a[47], 1);
      chk_eq("t1_ready_col1", rdy_a[95], 1);
      chk_eq("t1_line_cnt", cnt(ls_a, 0, 459), 2);
      chk_eq("t1_line_at", {ls_a[32], ls_a[240]}, 2'b11);
      chk_eq("t1_frame_cnt", cnt(fs_a, 0, 459), 1);
      chk_eq("t1_frame_at", fs_a[0], 1);
      chk_eq("t1_underrun", cnt(ur_a, 0, 459), 0);
      chk_eq("t1_idle_tx", cnt(tx_a, 448, 459), 0);

      // sync shape and first word bit pattern
      chk_eq("t2_fsync_high", cnt(tx_a, 0, 31), 32);
      chk_eq("t2_lsync_low", cnt(tx_a, 32, 47), 0);
      chk_eq("t2_start_bit", {tx_a[48], tx_a[49], tx_a[50], tx_a[51]}, 4'b1100);
      chk_eq("t2_d9_bit", {tx_a[52], tx_a[53], tx_a[54], tx_a[55]}, 4'b1100);
      chk_eq("t2_d8_bit", {tx_a[56], tx_a[57], tx_a[58], tx_a[59]}, 4'b0011);
      chk_eq("t2_word0", dec(48), 12'hD54);
      chk_eq("t2_row1_lsync", cnt(tx_a, 240, 255), 0);
      check_words("t2");

      // underrun on the third pixel of row 0
      val[2] = 1'b0;
      start_frame();
      capture(460, 1, -1);
      chk_eq("t3_underrun_cnt", cnt(ur_a, 0, 459), 1);
      chk_eq("t3_underrun_at", ur_a[144], 1);
      chk_eq("t3_ready_at", rdy_a[143], 1);
      chk_eq("t3_word2", dec(wstart(0, 2)), 12'h800);
      chk_eq("t3_oe_low", 460 - cnt(oe_a, 0, 459), 448);
      chk_eq("t3_ready_cnt", cnt(rdy_a, 0, 459), 8);
      check_words("t3");
      val[2] = 1'b1;

      // back-to-back frames
      start_frame();
      capture(520, 10000, -1);
      chk_eq("t4_oe_continuous", cnt(oe_a, 0, 519), 0);
      chk_eq("t4_frame_cnt", cnt(fs_a, 0, 519), 2);
      chk_eq("t4_frame2_at", fs_a[448], 1);
      chk_eq("t4_last_stop", {tx_a[444], tx_a[445], tx_a[446], tx_a[447]}, 4'b0011);
      chk_eq("t4_fsync2_high", cnt(tx_a, 448, 479), 32);
      chk_eq("t4_line2_at", ls_a[480], 1);
      ENABLE = 1'b0;
      begin
         int guard = 0;
         while (TX_OE_N !== 1'b1 && guard < 1000) begin
            @(posedge CLOCK); #1;
            PIX_VALID = 1'b1;
            guard++;
         end
         chk_eq("t4_back_to_idle", TX_OE_N, 1);
      end

      // asynchronous reset mid-word, then a clean frame
      start_frame();
      capture(300, 1, 200);
      chk_eq("t5_was_active", oe_a[200], 0);
      @(negedge CLOCK) RESET_N = 1'b1;
      start_frame();
      capture(460, 1, -1);
      chk_eq("t5_frame_at", fs_a[0], 1);
      chk_eq("t5_fsync_high", cnt(tx_a, 0, 31), 32);
      chk_eq("t5_line_at", ls_a[32], 1);
      chk_eq("t5_word0", dec(48), 12'hD54);
      chk_eq("t5_oe_low", 460 - cnt(oe_a, 0, 459), 448);

      // ENABLE pulsed for one cycle in IDLE
      @(posedge CLOCK); #1;
      start_frame();
      capture(460, 1, -1);
      chk_eq("t6_oe_low", 460 - cnt(oe_a, 0, 459), 448);
      chk_eq("t6_frame_cnt", cnt(fs_a, 0, 459), 1);
      chk_eq("t6_idle_after", oe_a[448], 1);
      chk_eq("t6_ready_cnt", cnt(rdy_a, 0, 459), 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/naneye_tx_encoder.md
Name: naneye_tx_encoder

Overview:
Serial line transmitter, the sensor-side counterpart of the NanEye-style receive path. It takes 10-bit parallel pixels over a valid/ready handshake and emits a Manchester-coded serial stream with frame and line sync periods. It is used as a synthesizable sensor emulator on the TX_DATA pin, for loopback into the deserializer and for board bring-up without a camera head.

Parameters:
D_WIDTH, 10, pixel width; a word is 1 start bit (1), D_WIDTH data bits MSB first, then 1 stop bit (0), so WORD_BITS = D_WIDTH+2.
COLS, 250, pixels per row.
ROWS, 250, rows per frame.
HALF_DIV, 1, CLOCK cycles per Manchester half-bit (HALF_DIV >= 1); one bit period = 2*HALF_DIV cycles.
FRAME_SYNC_BITS, 16, bit periods of the frame sync (constant high).
LINE_SYNC_BITS, 8, bit periods of the line sync (constant low).

Ports:
CLOCK  in  1  line clock; all logic on the rising edge.
RESET_N  in  1  asynchronous active-low reset.
ENABLE  in  1  level; start frames and keep streaming while high.
PIX_DATA  in  D_WIDTH  pixel value.
PIX_VALID  in  1  PIX_DATA is valid.
PIX_READY  out  1  registered; a transfer occurs on the edge where PIX_VALID and PIX_READY are both 1.
TX_DATA  out  1  registered serial output.
TX_OE_N  out  1  low while a frame is being sent.
FRAME_START  out  1  1-cycle pulse on the first cycle of FSYNC.
LINE_START  out  1  1-cycle pulse on the first cycle of each LSYNC.
UNDERRUN  out  1  1-cycle pulse when a pixel was due and PIX_VALID was 0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): state IDLE, all counters 0; TX_DATA=0, TX_OE_N=1, PIX_READY=0, FRAME_START=0, LINE_START=0, UNDERRUN=0.
- Counters:
  - half counter 0..HALF_DIV-1
  - phase bit (first or second half-bit)
  - bit counter 0..WORD_BITS-1 (or 0..SYNC_BITS-1 during sync)
  - col counter 0..COLS-1
  - row counter 0..ROWS-1
  - widths are $clog2 of the range, minimum 1.
- States:
  - IDLE: TX_OE_N=1, TX_DATA=0. ENABLE sampled 1 -> FSYNC on the next cycle. TX_OE_N goes low and FRAME_START pulses in the same cycle.
  - FSYNC: TX_DATA=1 for FRAME_SYNC_BITS*2*HALF_DIV cycles. This is deliberately not Manchester (a violation), which lets the receiver find the frame boundary. Then -> LSYNC with row=0.
  - LSYNC: TX_DATA=0 for LINE_SYNC_BITS*2*HALF_DIV cycles; LINE_START pulses on the first cycle. Then -> PIXEL with col=0.
  - PIXEL: COLS words. Each bit is Manchester-coded: 1 = high half then low half; 0 = low half then high half. Bit order is start, d[D_WIDTH-1]..d[0], stop.
  - End of the last word in a row:
    - row<ROWS-1: row+1, -> LSYNC.
    - last row, ENABLE=1: -> FSYNC (back-to-back frames with no idle gap; FRAME_START pulses again).
    - last row, ENABLE=0: -> IDLE, TX_OE_N=1.
- ENABLE is sampled only in IDLE and at end of frame. Dropping it mid-frame never truncates a frame.
- Pixel fetch:
  - PIX_READY=1 for exactly one cycle: the last cycle of the period before each word. That period is the last sync cycle for col 0, otherwise the last cycle of the previous stop bit.
  - PIX_VALID=1 on that edge: the word loads from PIX_DATA.
  - PIX_VALID=0: the word loads with 0, UNDERRUN pulses on the next cycle, and line timing is unchanged. No retry and no stall.
  - Exactly COLS*ROWS PIX_READY pulses per frame.
- Frame length is (FRAME_SYNC_BITS + ROWS*(LINE_SYNC_BITS + COLS*WORD_BITS)) * 2*HALF_DIV cycles of TX_OE_N low.
- The TX_DATA edge timing is fixed by counters only and is independent of handshake outcomes.

Test Plan:
1. Parameters COLS=4, ROWS=2, HALF_DIV=2, FRAME_SYNC_BITS=8, LINE_SYNC_BITS=4. Hold ENABLE=1 for one frame, then drop it; PIX_VALID is always 1.
   -> TX_OE_N low for exactly 448 cycles, 8 PIX_READY pulses, LINE_START twice, FRAME_START once, then IDLE.
2. Same parameters, pixels 0x2AA, 0x155, 0x3FF, 0x000.
   -> After the 32-cycle FSYNC high and 16-cycle LSYNC low, the first word's bits decode to 1,1010101010,0. Each half-bit is 2 cycles, e.g. the start bit is 1,1,0,0.
3. PIX_VALID=0 for the 3rd pixel of row 0.
   -> UNDERRUN pulses once; that word decodes as 1,0000000000,0; frame length is still 448 cycles.
4. ENABLE held high.
   -> The 2nd FSYNC starts on the cycle after the last stop bit of frame 1, TX_OE_N stays low continuously, and FRAME_START pulses at cycle 448.
5. RESET_N asserted at cycle 200 mid-word.
   -> All outputs take their reset values without waiting for a clock edge. After release with ENABLE=1, the next frame starts cleanly with FSYNC and row/col=0.
6. ENABLE pulsed high for 1 cycle in IDLE.
   -> One full frame (448 cycles), then IDLE.
